message_slicer_scheduler: RTL and testbench

// - Shares one message_slicer between N_SOURCES message producers. Each producer

---
 rtl/message_slicer_scheduler_pkg.sv | 17 +
 rtl/message_slicer_scheduler_if.sv | 33 +++
 rtl/message_slicer_scheduler_rr_arbiter.sv | 30 +++
 rtl/message_slicer_scheduler.sv | 125 ++++++++++++
 tb/tb_message_slicer_scheduler.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/message_slicer_scheduler_pkg.sv
// Shared constants and helpers for the message slicer scheduler.
package message_slicer_scheduler_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  function automatic int unsigned msg_width(input int unsigned width, input int unsigned slices);
    return width * slices;
  endfunction

endpackage

// File: rtl/message_slicer_scheduler_if.sv
// Producer-side and slicer-side bus of the scheduler.
// drop_count exists only when MESSAGE_SCHED_DROP_COUNT_EN is defined.
interface message_slicer_scheduler_if
  import message_slicer_scheduler_pkg::*;
#(
  parameter int unsigned N_SOURCES = 4,
  parameter int unsigned N_SLICES  = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SRC_W     = 2
);
  localparam int unsigned MSG_W = msg_width(WIDTH, N_SLICES);

  logic [N_SOURCES*MSG_W-1:0] in_data;
  logic [N_SOURCES-1:0]       in_nd;
  logic [MSG_W-1:0]           out_data;
  logic                       out_nd;
  logic [SRC_W-1:0]           out_src;
  logic                       error;
`ifdef MESSAGE_SCHED_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0]      drop_count;

  modport master (output in_data, in_nd,
                  input  out_data, out_nd, out_src, error, drop_count);
  modport slave  (input  in_data, in_nd,
                  output out_data, out_nd, out_src, error, drop_count);
`else
  modport master (output in_data, in_nd,
                  input  out_data, out_nd, out_src, error);
  modport slave  (input  in_data, in_nd,
                  output out_data, out_nd, out_src, error);
`endif

endinterface

// File: rtl/message_slicer_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after `last`, wrapping.
module message_slicer_scheduler_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned SRC_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] last,
  output logic [SRC_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i > int'(last))) begin
        any       = 1'b1;
        grant_idx = SRC_W'(i);
      end
    end
    // Nothing above the pointer: wrap and take the lowest requester.
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any       = 1'b1;
        grant_idx = SRC_W'(i);
      end
    end
  end

endmodule

// File: rtl/message_slicer_scheduler.sv
// Round-robin scheduler feeding one message_slicer from N_SOURCES one-deep slots.
// Optional MESSAGE_SCHED_DROP_COUNT_EN adds a saturating drop counter.
module message_slicer_scheduler
  import message_slicer_scheduler_pkg::*;
#(
  parameter int unsigned N_SOURCES = 4,
  parameter int unsigned N_SLICES  = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SRC_W     = 2
) (
  input logic clk,
  input logic rst_n,
  message_slicer_scheduler_if.slave bus
);
  localparam int unsigned MSG_W   = msg_width(WIDTH, N_SLICES);
  localparam int unsigned GAP_W   = (clog2(N_SLICES) > 0) ? clog2(N_SLICES) : 1;
  localparam int unsigned SRC_MIN = (clog2(N_SOURCES) > 0) ? clog2(N_SOURCES) : 1;

  if (SRC_W < SRC_MIN) begin : g_bad_src_w
    $error("SRC_W too narrow for N_SOURCES");
  end

  logic [N_SOURCES-1:0] pend_q, pend_d, drop;
  logic [MSG_W-1:0]     slot_q [N_SOURCES];
  logic [MSG_W-1:0]     slot_d [N_SOURCES];
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [SRC_W-1:0]     rr_q, rr_d, grant_idx;
  logic                 any_req, issue;
  logic [MSG_W-1:0]     out_data_q, out_data_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;
  logic                 out_nd_q, error_q;

  message_slicer_scheduler_rr_arbiter #(
    .N     (N_SOURCES),
    .SRC_W (SRC_W)
  ) u_rr_arbiter (
    .req       (pend_q),
    .last      (rr_q),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  assign issue = (gap_q == '0) && any_req;

  always_comb begin
    pend_d     = pend_q;
    slot_d     = slot_q;
    drop       = '0;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    rr_d       = rr_q;
    for (int i = 0; i < N_SOURCES; i++) begin
      if (issue && (grant_idx == SRC_W'(i))) begin
        out_data_d = slot_q[i];
        out_src_d  = SRC_W'(i);
        rr_d       = SRC_W'(i);
        pend_d[i]  = 1'b0;
      end
      // A slot being granted this edge is free to accept a same-cycle refill.
      if (bus.in_nd[i]) begin
        if (!pend_q[i] || (issue && (grant_idx == SRC_W'(i)))) begin
          slot_d[i] = bus.in_data[i*MSG_W +: MSG_W];
          pend_d[i] = 1'b1;
        end else begin
          drop[i] = 1'b1;
        end
      end
    end
    if (issue) begin
      gap_d = GAP_W'(N_SLICES - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end else begin
      gap_d = gap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      gap_q      <= '0;
      rr_q       <= SRC_W'(N_SOURCES - 1);
      out_data_q <= '0;
      out_src_q  <= '0;
      out_nd_q   <= 1'b0;
      error_q    <= 1'b0;
      for (int i = 0; i < N_SOURCES; i++) slot_q[i] <= '0;
    end else begin
      pend_q     <= pend_d;
      gap_q      <= gap_d;
      rr_q       <= rr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      out_nd_q   <= issue;
      error_q    <= |drop;
      for (int i = 0; i < N_SOURCES; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_nd   = out_nd_q;
  assign bus.out_src  = out_src_q;
  assign bus.error    = error_q;

`ifdef MESSAGE_SCHED_DROP_COUNT_EN
  localparam int unsigned DROP_SUM_W = DROP_CNT_W + 1;

  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_SUM_W-1:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < N_SOURCES; i++) drop_sum = drop_sum + DROP_SUM_W'(drop[i]);
    drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_message_slicer_scheduler.sv
// Directed bench for message_slicer_scheduler: vector table plus reset/contention sequences.
module tb_message_slicer_scheduler;
  localparam int unsigned NS    = 4;
  localparam int unsigned NSL   = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned SW    = 2;
  localparam int unsigned MSG_W = W * NSL;
  localparam int unsigned NVEC  = 22;

  typedef struct packed {
    logic [3:0]      nd;
    logic [3:0][7:0] tag;
    logic            exp_nd;
    logic [1:0]      exp_src;
    logic [7:0]      exp_tag;
    logic            exp_err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  message_slicer_scheduler_if #(.N_SOURCES(NS), .N_SLICES(NSL), .WIDTH(W), .SRC_W(SW)) bus ();

  message_slicer_scheduler #(
    .N_SOURCES (NS),
    .N_SLICES  (NSL),
    .WIDTH     (W),
    .SRC_W     (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag 0 stands for the all-zero message seen after reset.
  function automatic logic [MSG_W-1:0] mk(input logic [7:0] tag);
    logic [MSG_W-1:0] m;
    m = '0;
    if (tag != 8'h00) begin
      for (int s = 0; s < NSL; s++) m[s*W +: W] = {tag, 8'(s), 16'hC0DE};
    end
    return m;
  endfunction

  function automatic vec_t v(input logic [3:0] nd, input logic [7:0] t3, input logic [7:0] t2,
                             input logic [7:0] t1, input logic [7:0] t0, input logic enb,
                             input logic [1:0] src, input logic [7:0] etag, input logic err);
    vec_t r;
    r.nd      = nd;
    r.tag     = {t3, t2, t1, t0};
    r.exp_nd  = enb;
    r.exp_src = src;
    r.exp_tag = etag;
    r.exp_err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [MSG_W-1:0] got,
                     input logic [MSG_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic enb, input logic [1:0] src,
                         input logic [7:0] etag, input logic err);
    chk({name, " out_nd"}, MSG_W'(bus.out_nd), MSG_W'(enb));
    chk({name, " out_src"}, MSG_W'(bus.out_src), MSG_W'(src));
    chk({name, " out_data"}, bus.out_data, mk(etag));
    chk({name, " error"}, MSG_W'(bus.error), MSG_W'(err));
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic [3:0] nd, input logic [3:0][7:0] tag);
    logic [NS*MSG_W-1:0] d;
    @(negedge clk);
    d = '0;
    for (int s = 0; s < NS; s++) if (nd[s]) d[s*MSG_W +: MSG_W] = mk(tag[s]);
    bus.in_nd   = nd;
    bus.in_data = d;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [NVEC];

  initial begin
    logic       enb;
    logic [1:0] src;
    logic [7:0] etag;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_nd   = '0;
    bus.in_data = '0;

    // single source, overwrite while gapped, same-cycle refill, rr wrap
    tbl[0]  = v(4'b0001, 8'h00, 8'h00, 8'h00, 8'h11, 1'b0, 2'd0, 8'h00, 1'b0);
    tbl[1]  = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0, 8'h11, 1'b0);
    tbl[2]  = v(4'b0100, 8'h00, 8'h21, 8'h00, 8'h00, 1'b0, 2'd0, 8'h11, 1'b0);
    tbl[3]  = v(4'b0100, 8'h00, 8'h22, 8'h00, 8'h00, 1'b0, 2'd0, 8'h11, 1'b1);
    tbl[4]  = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 8'h11, 1'b0);
    tbl[5]  = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd2, 8'h21, 1'b0);
    tbl[6]  = v(4'b0010, 8'h00, 8'h00, 8'h31, 8'h00, 1'b0, 2'd2, 8'h21, 1'b0);
    tbl[7]  = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 8'h21, 1'b0);
    tbl[8]  = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 8'h21, 1'b0);
    tbl[9]  = v(4'b0010, 8'h00, 8'h00, 8'h32, 8'h00, 1'b1, 2'd1, 8'h31, 1'b0);
    tbl[10] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 8'h31, 1'b0);
    tbl[11] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 8'h31, 1'b0);
    tbl[12] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 8'h31, 1'b0);
    tbl[13] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd1, 8'h32, 1'b0);
    tbl[14] = v(4'b1001, 8'h44, 8'h00, 8'h00, 8'h41, 1'b0, 2'd1, 8'h32, 1'b0);
    tbl[15] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 8'h32, 1'b0);
    tbl[16] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 8'h32, 1'b0);
    tbl[17] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd3, 8'h44, 1'b0);
    tbl[18] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd3, 8'h44, 1'b0);
    tbl[19] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd3, 8'h44, 1'b0);
    tbl[20] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd3, 8'h44, 1'b0);
    tbl[21] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0, 8'h41, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].nd, tbl[i].tag);
      chk_out($sformatf("row%0d", i), tbl[i].exp_nd, tbl[i].exp_src, tbl[i].exp_tag,
              tbl[i].exp_err);
    end
`ifdef MESSAGE_SCHED_DROP_COUNT_EN
    chk("drop_count", MSG_W'(bus.drop_count), MSG_W'(1));
`endif

    // Async reset: outputs clear before any clock edge.
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: order 0,1,2,3 spaced by N_SLICES.
    step(4'b1111, {8'hB3, 8'hB2, 8'hB1, 8'hB0});
    chk_out("cont_cap", 1'b0, 2'd0, 8'h00, 1'b0);
    src  = 2'd0;
    etag = 8'h00;
    for (int j = 1; j <= 16; j++) begin
      step(4'b0000, '0);
      enb = ((j % 4) == 1);
      if (enb) begin
        src  = 2'((j - 1) / 4);
        etag = 8'hB0 + 8'((j - 1) / 4);
      end
      chk_out($sformatf("cont%0d", j), enb, src, etag, 1'b0);
    end

    // Reset with three slots pending and the gap counter mid-count.
    step(4'b1111, {8'hC3, 8'hC2, 8'hC1, 8'hC0});
    chk_out("mid_cap", 1'b0, 2'd3, 8'hB3, 1'b0);
    step(4'b0000, '0);
    chk_out("mid_issue", 1'b1, 2'd0, 8'hC0, 1'b0);
    step(4'b0000, '0);
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step(4'b0000, '0);
      chk($sformatf("post_reset%0d out_nd", j), MSG_W'(bus.out_nd), MSG_W'(0));
    end
    step(4'b0101, {8'h00, 8'h62, 8'h00, 8'h60});
    chk_out("post_cap", 1'b0, 2'd0, 8'h00, 1'b0);
    step(4'b0000, '0);
    chk_out("post_first", 1'b1, 2'd0, 8'h60, 1'b0);
    repeat (3) step(4'b0000, '0);
    step(4'b0000, '0);
    chk_out("post_second", 1'b1, 2'd2, 8'h62, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
